// File: rtl/referee_merge_pkg.sv
// Shared transaction-layer definitions: layer FSM state encodings and word width,
// used by both the distribution and merge referees.
package referee_merge_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [3:0] {
    ST_INIT   = 4'b0001,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } layer_st_e;

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/referee_merge_rr_pick4.sv
// Combinational 4-way round-robin picker: first requester at or after rr_i (mod 4).
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] rr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the closest requester is written last and wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_i + 2'(k);
      if (req_i[cand]) begin
        gnt_o = 4'b0001 << cand;
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/referee_merge.sv
// Merge referee: round-robin pops from four VC FIFOs into one downstream FIFO,
// with a two-stage registered data path (pop -> word valid -> push).
module referee_merge
  import referee_merge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              almost_full,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  output logic              push,
  output logic [DATA_W-1:0] data_out
);

  logic [3:0]        pop_q, pop_d, req, gnt;
  logic [1:0]        rr_q, rr_d, g_idx, g1_q, g1_d;
  logic              any, v1_q, v1_d, push_q, push_d, operating;
  logic [DATA_W-1:0] data_q, data_d, sel_data;

  assign operating = (state == ST_IDLE) || (state == ST_ACTIVE);

  // A FIFO popped last cycle is skipped so its registered empty flag can catch up.
  assign req = ~{empty_3, empty_2, empty_1, empty_0} & ~pop_q & {4{operating & ~almost_full}};

  rr_pick4 u_pick (
    .req_i (req),
    .rr_i  (rr_q),
    .gnt_o (gnt),
    .idx_o (g_idx),
    .any_o (any)
  );

  always_comb begin
    sel_data = data_in_0;
    case (g1_q)
      2'd1:    sel_data = data_in_1;
      2'd2:    sel_data = data_in_2;
      2'd3:    sel_data = data_in_3;
      default: sel_data = data_in_0;
    endcase
  end

  always_comb begin
    pop_d  = gnt;
    rr_d   = any ? g_idx + 2'd1 : rr_q;
    v1_d   = |pop_q;
    g1_d   = (|pop_q) ? onehot_idx(pop_q) : g1_q;
    push_d = v1_q;
    data_d = v1_q ? sel_data : data_q;
    if (state == ST_INIT) begin
      pop_d  = '0;
      rr_d   = '0;
      v1_d   = 1'b0;
      g1_d   = '0;
      push_d = 1'b0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_q  <= '0;
      rr_q   <= '0;
      v1_q   <= 1'b0;
      g1_q   <= '0;
      push_q <= 1'b0;
      data_q <= '0;
    end else begin
      pop_q  <= pop_d;
      rr_q   <= rr_d;
      v1_q   <= v1_d;
      g1_q   <= g1_d;
      push_q <= push_d;
      data_q <= data_d;
    end
  end

  assign {pop_3, pop_2, pop_1, pop_0} = pop_q;
  assign push     = push_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_referee_merge.sv
// Self-checking bench for referee_merge: TB-owned FIFO models plus a cycle-level
// reference built from the grant/pipeline rules.
module tb_referee_merge;
  import referee_merge_pkg::*;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset_L;
  logic [3:0]   state;
  logic         empty_0, empty_1, empty_2, empty_3;
  logic [W-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic         almost_full;
  logic         pop_0, pop_1, pop_2, pop_3;
  logic         push;
  logic [W-1:0] data_out;

  always #5 clk = ~clk;

  referee_merge dut (
    .clk(clk), .reset_L(reset_L), .state(state),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2), .empty_3(empty_3),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .almost_full(almost_full),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .push(push), .data_out(data_out)
  );

  // upstream FIFO models
  logic [W-1:0] q0[$], q1[$], q2[$], q3[$];
  logic [W-1:0] din[4];
  logic         emp[4];
  assign {data_in_0, data_in_1, data_in_2, data_in_3} = {din[0], din[1], din[2], din[3]};
  assign {empty_0, empty_1, empty_2, empty_3} = {emp[0], emp[1], emp[2], emp[3]};

  // reference model
  logic [3:0]   m_pop;
  int           m_rr;
  bit           m_pend;
  logic [W-1:0] m_pend_word;
  logic         m_push;
  logic [W-1:0] m_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [3:0] dut_pop();
    return {pop_3, pop_2, pop_1, pop_0};
  endfunction

  function automatic int pop_idx(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic load(input int i, input logic [W-1:0] w);
    case (i)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    emp[i] = 1'b0;
  endtask

  task automatic fifo_pop(input int i);
    case (i)
      0: din[0] = q0.pop_front();
      1: din[1] = q1.pop_front();
      2: din[2] = q2.pop_front();
      default: din[3] = q3.pop_front();
    endcase
  endtask

  // One clock: FIFOs react to the sampled pops, the model applies the grant rules.
  task automatic tick();
    logic [3:0] st, pre_pop, mprev;
    logic       af, rst;
    logic       e[4];
    int         g;
    st = state; af = almost_full; rst = reset_L;
    pre_pop = dut_pop(); mprev = m_pop;
    for (int i = 0; i < 4; i++) e[i] = emp[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pre_pop[i] && qsize(i) > 0) fifo_pop(i);
    if (!rst || st == ST_INIT) begin
      m_pop = '0; m_rr = 0; m_pend = 0; m_pend_word = '0; m_push = 1'b0; m_data = '0;
    end else begin
      m_push = m_pend;
      if (m_pend) m_data = m_pend_word;
      m_pend = (mprev != 0);
      for (int i = 0; i < 4; i++) if (mprev[i]) m_pend_word = din[i];
      m_pop = '0;
      if (st == ST_IDLE || st == ST_ACTIVE) begin
        for (int k = 0; k < 4; k++) begin
          g = (m_rr + k) % 4;
          if (m_pop == 0 && !e[g] && !mprev[g] && !af) begin
            m_pop[g] = 1'b1;
            m_rr = (g + 1) % 4;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) emp[i] = (qsize(i) == 0);
    cyc++;
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int i = 0; i < 4; i++) emp[i] = 1'b1;
    almost_full = 1'b0;
    state = ST_INIT;
    tick();
  endtask

  task automatic test_reset();
    reset_L = 1'b0; state = ST_ACTIVE; almost_full = 1'b0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) load(i, W'(12'h300 + 16 * i + j));
    tick();
    n_checks++;
    if ({dut_pop(), push, data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got pop=%b push=%b data=%h required all zero", dut_pop(), push, data_out);
    end
    reset_L = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL reset_run cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
    end
    #3 reset_L = 1'b0;
    #1;
    n_checks++;
    if ({dut_pop(), push, data_out} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got pop=%b push=%b data=%h required all zero", dut_pop(), push, data_out);
    end
    tick();
    reset_L = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    state = ST_INIT;
    tick();
    n_checks++;
    if ({dut_pop(), push, data_out} !== '0) begin
      n_fail++;
      $display("FAIL init_clear got pop=%b push=%b data=%h required all zero", dut_pop(), push, data_out);
    end
    state = ST_ACTIVE;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (c < 2 && push !== 1'b0) begin
        n_fail++;
        $display("FAIL init_discard cyc=%0d got push=%b required 0", cyc, push);
      end
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL init_resume cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
    end
  endtask

  task automatic test_rr_order();
    int grants[$];
    logic [W-1:0] pushed[$];
    int exp_g[5] = '{0, 1, 2, 3, 0};
    clear_all();
    for (int i = 0; i < 4; i++) begin
      load(i, W'(12'hA00 + i));
      load(i, W'(12'hB00 + i));
    end
    state = ST_ACTIVE;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL rr_order cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
      if (dut_pop() != 0) grants.push_back(pop_idx(dut_pop()));
      if (push) pushed.push_back(data_out);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (k >= grants.size() || grants[k] != exp_g[k]) begin
        n_fail++;
        $display("FAIL rr_grant_seq idx=%0d got %0d required %0d", k,
                 (k < grants.size()) ? grants[k] : -1, exp_g[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= pushed.size() || pushed[k] !== W'(12'hA00 + k)) begin
        n_fail++;
        $display("FAIL rr_push_data idx=%0d got %h required %h", k,
                 (k < pushed.size()) ? pushed[k] : W'(0), W'(12'hA00 + k));
      end
    end
  endtask

  task automatic test_single_fifo();
    logic [W-1:0] words[3];
    logic         exp_p2[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] pushed[$];
    clear_all();
    for (int j = 0; j < 3; j++) begin
      words[j] = W'($urandom);
      load(2, words[j]);
    end
    state = ST_ACTIVE;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL single_fifo cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
      if (c < 5) begin
        n_checks++;
        if ({pop_3, pop_2, pop_1, pop_0} !== {1'b0, exp_p2[c], 2'b00}) begin
          n_fail++;
          $display("FAIL single_pop_pattern step=%0d got pop=%b required pop_2=%b only", c, dut_pop(), exp_p2[c]);
        end
      end
      if (push) pushed.push_back(data_out);
    end
    n_checks++;
    if (pushed.size() != 3 || pushed[0] !== words[0] || pushed[1] !== words[1] || pushed[2] !== words[2]) begin
      n_fail++;
      $display("FAIL single_push_count got %0d pushes required 3 matching words", pushed.size());
    end
  endtask

  task automatic test_pair_wrap();
    int grants[$];
    clear_all();
    for (int j = 0; j < 4; j++) begin
      load(1, W'($urandom));
      load(3, W'($urandom));
    end
    state = ST_IDLE;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL pair_wrap cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
      if (c < 6) grants.push_back(pop_idx(dut_pop()));
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (grants[k] != ((k % 2 == 0) ? 1 : 3)) begin
        n_fail++;
        $display("FAIL pair_grant_seq idx=%0d got %0d required %0d", k, grants[k], (k % 2 == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_almost_full();
    clear_all();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 8; j++) load(i, W'($urandom));
    state = ST_ACTIVE;
    for (int c = 0; c < 50; c++) begin
      almost_full = ($urandom_range(0, 2) == 0);
      tick();
      n_checks++;
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL almost_full cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
    end
    almost_full = 1'b0;
  endtask

  task automatic test_hold();
    clear_all();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) load(i, W'($urandom));
    state = ST_ACTIVE;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) state = 4'b0010;
      if (c == 9) state = ST_ACTIVE;
      tick();
      n_checks++;
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL hold cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] st_tab[6] = '{ST_ACTIVE, ST_ACTIVE, ST_IDLE, 4'b0010, 4'b0000, ST_INIT};
    clear_all();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (qsize(i) < 3 && $urandom_range(0, 3) == 0) load(i, W'($urandom));
      if ($urandom_range(0, 7) == 0) state = st_tab[$urandom_range(0, 5)];
      if (state == ST_INIT && $urandom_range(0, 1) == 0) state = ST_ACTIVE;
      almost_full = ($urandom_range(0, 5) == 0);
      tick();
      n_checks++;
      if ({dut_pop(), push, data_out} !== {m_pop, m_push, m_data}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got pop=%b push=%b data=%h required pop=%b push=%b data=%h",
                 cyc, dut_pop(), push, data_out, m_pop, m_push, m_data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      din[i] = '0;
      emp[i] = 1'b1;
    end
    m_pop = '0; m_rr = 0; m_pend = 0; m_pend_word = '0; m_push = 1'b0; m_data = '0;
    state = ST_INIT; almost_full = 1'b0; reset_L = 1'b0;
    test_reset();
    test_rr_order();
    test_single_fifo();
    test_pair_wrap();
    test_almost_full();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/referee_merge.md
Name: referee_merge

Overview:
- Merge-side counterpart of the 1-to-4 distribution referee in the transaction layer.
- Pops words from four per-virtual-channel FIFOs in round-robin order and pushes them into a single downstream FIFO.
- Gated by the link state word from the layer FSM.
- Carries the data path: it registers the selected FIFO word and presents it with push.

Parameters:
- DATA_W, 12, width of each FIFO word.

Ports:
- clk, input, 1, single clock, rising edge.
- reset_L, input, 1, asynchronous active-low reset.
- state, input, 4, layer FSM state: 'b0001 INIT; 'b0100 IDLE and 'b1000 ACTIVE are the operating states; all other values are hold states.
- empty_0..empty_3, input, 1 each, upstream FIFO empty flags.
- data_in_0..data_in_3, input, DATA_W each, upstream FIFO read data.
- almost_full, input, 1, downstream FIFO almost-full flag.
- pop_0..pop_3, output, 1 each, upstream FIFO pops; registered, one-hot or zero.
- push, output, 1, downstream FIFO push; registered.
- data_out, output, DATA_W, word pushed downstream; registered.

Behaviour:
- Reset (reset_L = 0, asynchronous):
  - pop_0..pop_3, push and data_out are 0.
  - Round-robin pointer rr = 0.
  - In-flight valid flag v1 = 0; grant delay register g1 = 0.
  - Previous-grant register last = none.
- state == INIT is a synchronous clear with the same values as reset, evaluated each clock edge.
- Eligibility, evaluated in IDLE/ACTIVE at each edge:
  - FIFO i is eligible when empty_i = 0, i is not the FIFO whose pop is currently high, and almost_full = 0.
  - The FIFO popped in cycle k is therefore never popped in cycle k+1. This prevents underflow against registered empty flags; a single busy FIFO is popped every other cycle.
- Grant: the first eligible index searching rr, rr+1, rr+2, rr+3 (mod 4).
  - Register pop_g = 1, all other pops 0, and rr <= g+1 (2-bit wrap).
  - If nothing is eligible: all pops 0, rr unchanged.
- Upstream read timing: a FIFO presents its word on the edge that samples its pop high, so the word is valid in the cycle after pop.
- Data pipeline (pop to push latency is 2 cycles):
  - Edge where pop_g is sampled high: v1 <= 1, g1 <= g.
  - Next edge: push <= v1, data_out <= data_in_g1 when v1, otherwise data_out holds.
- push is high for exactly one cycle per popped word. Words leave in grant order with no loss and no duplication.
- almost_full is sampled only for new grants. Up to 2 words can still be in flight after it rises, so the downstream almost-full threshold must leave at least 2 free slots.
- Hold states (state not INIT/IDLE/ACTIVE): no new pops and rr frozen; in-flight words still drain (push completes).
- Simultaneous events:
  - almost_full rising in the same cycle as a grant blocks that grant.
  - INIT or reset mid-operation discards in-flight words.
- Pointer wrap: after g = 3, rr = 0.

Decomposition:
- Shared transaction-layer package:
  - State encodings ST_INIT = 'b0001, ST_IDLE = 'b0100, ST_ACTIVE = 'b1000.
  - DATA_W default.
  - Shared by both referees.
- One natural sub-module, rr_pick4: combinational 4-input round-robin priority picker (request vector, rr pointer → one-hot grant, any).

Test Plan:
- Reset/INIT: reset_L = 0 with all FIFOs full → all pops, push and data_out = 0. Repeat with state = INIT mid-stream → same, and in-flight word not pushed.
- All four FIFOs non-empty (words 0xA00..0xA03), ACTIVE → pops in order 0,1,2,3,0 on consecutive cycles; push pattern and data_out = 0xA00, 0xA01, 0xA02, 0xA03, each 2 cycles after its pop.
- Only FIFO 2 non-empty (3 words) → pop_2 = 1,0,1,0,1 on alternate cycles; exactly 3 pushes with correct data; pop_0/1/3 stay 0.
- Only FIFOs 1 and 3 non-empty → pops alternate 1,3,1,3 back-to-back; rr wraps 3 → 0 → next grant 1.
- almost_full asserted while streaming → no pop on the following edge; at most 2 further pushes; pops resume the cycle after almost_full drops, continuing from rr.
- state = 'b0010 (hold) with words in flight → pushes for in-flight words complete, no new pops; returning to ACTIVE resumes from the saved rr.
